// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings.
// Imported by uart_rx now and intended for reuse by uart_tx.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Reset value is a parameter (1 by default, matching an idle-high line).
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high
//   d     - asynchronous input
//   q     - synchronized output, 2 clk latency
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Serial UART receiver with oversampled bit recovery (8N1, optional parity).
// rx_tick is a clk-synchronous enable at BAUD*OVERSAMPLE, never a clock.
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high
//   rx_tick    - one-clk oversample enable pulse
//   rx         - asynchronous serial input, idle high
//   rx_data    - last received word, LSB first on the line
//   rx_valid   - one-clk pulse: frame complete, data/flags valid
//   frame_err  - stop bit sampled 0 (held until next rx_valid)
//   parity_err - parity mismatch (0 when PARITY_EN=0)
//   busy       - receiver not idle
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  uart_state_e          state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // rx_valid is the only output not gated by rx_tick, so it never repeats.
      rx_valid <= 1'b0;
      if (rx_tick) begin
        case (state)
          ST_IDLE: begin
            if (!rx_s) begin
              state    <= ST_START;
              tick_cnt <= '0;
              busy     <= 1'b1;
            end
          end
          ST_START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              if (rx_s) begin
                // Line back high at mid start bit: glitch, not a frame.
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                bit_cnt <= '0;
                state   <= ST_DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                state <= PARITY_EN ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_PARITY: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              par_bit  <= rx_s;
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt   <= '0;
              rx_data    <= shreg;
              rx_valid   <= 1'b1;
              frame_err  <= ~rx_s;
              parity_err <= PARITY_EN ? (par_bit != ((^shreg) ^ PARITY_ODD)) : 1'b0;
              if (rx_s) begin
                // Return at the stop-bit centre so a back-to-back start edge is caught.
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= ST_WAIT_HIGH;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_WAIT_HIGH: begin
            // A held-low line (break) must not be decoded as repeated zero frames.
            if (rx_s) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_tick;
  logic       rx;
  logic       rx_p;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, frame_err, parity_err, busy;
  logic       rx_valid_p, frame_err_p, parity_err_p, busy_p;

  int errors = 0;
  int checks = 0;

  int         vcount = 0;
  int         vcount_p = 0;
  logic [7:0] last_data, last_data_p;
  logic       last_fe, last_pe, last_fe_p, last_pe_p;
  logic [7:0] data_q[$];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_tick    (rx_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk        (clk),
    .reset      (reset),
    .rx_tick    (rx_tick),
    .rx         (rx_p),
    .rx_data    (rx_data_p),
    .rx_valid   (rx_valid_p),
    .frame_err  (frame_err_p),
    .parity_err (parity_err_p),
    .busy       (busy_p)
  );

  always #5 clk = ~clk;

  // Oversample enable: one clk high every 4 clk.
  initial begin
    rx_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      rx_tick = 1'b1;
      @(negedge clk);
      rx_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      vcount++;
      last_data = rx_data;
      last_fe   = frame_err;
      last_pe   = parity_err;
      data_q.push_back(rx_data);
    end
    if (rx_valid_p === 1'b1) begin
      vcount_p++;
      last_data_p = rx_data_p;
      last_fe_p   = frame_err_p;
      last_pe_p   = parity_err_p;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit period = 8 ticks * 4 clk.
  task automatic drive_bit(input bit on_p, input logic v);
    if (on_p) rx_p = v;
    else rx = v;
    wait_clk(32);
  endtask

  task automatic send_frame(input bit on_p, input logic [7:0] d, input bit with_par,
                            input logic par, input logic stop);
    drive_bit(on_p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(on_p, d[i]);
    if (with_par) drive_bit(on_p, par);
    drive_bit(on_p, stop);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_clk(4);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (busy_p !== 1'b0) begin errors++; $display("FAIL reset_busy_p: got %b expected 0", busy_p); end
    reset = 1'b0;
    wait_clk(40);
  endtask

  task automatic test_single;
    int v0;
    v0 = vcount;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_clk(8);
    checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL single_count: got %0d expected %0d", vcount - v0, 1); end
    checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", last_data); end
    checks++; if (last_fe !== 1'b0) begin errors++; $display("FAIL single_frame_err: got %b expected 0", last_fe); end
    checks++; if (last_pe !== 1'b0) begin errors++; $display("FAIL single_parity_err: got %b expected 0", last_pe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = vcount;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    wait_clk(16);
    checks++; if (vcount !== v0 + 2) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", vcount - v0, 2); end
    if (data_q.size() >= 2) begin
      checks++; if (data_q[data_q.size()-2] !== 8'h3C) begin errors++; $display("FAIL b2b_first: got %h expected 3c", data_q[data_q.size()-2]); end
      checks++; if (data_q[data_q.size()-1] !== 8'hC3) begin errors++; $display("FAIL b2b_second: got %h expected c3", data_q[data_q.size()-1]); end
    end else begin
      checks++; errors++; $display("FAIL b2b_queue: got %0d words expected at least 2", data_q.size());
    end
    checks++; if (last_fe !== 1'b0) begin errors++; $display("FAIL b2b_frame_err: got %b expected 0", last_fe); end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = vcount;
    rx = 1'b0;
    wait_clk(8);
    rx = 1'b1;
    wait_clk(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b expected 1", busy); end
    wait_clk(40);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b expected 0", busy); end
    checks++; if (vcount !== v0) begin errors++; $display("FAIL glitch_no_valid: got %0d expected 0", vcount - v0); end
  endtask

  task automatic test_framing;
    int v0;
    v0 = vcount;
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    wait_clk(64);
    checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL frame_count: got %0d expected %0d", vcount - v0, 1); end
    checks++; if (last_data !== 8'h55) begin errors++; $display("FAIL frame_data: got %h expected 55", last_data); end
    checks++; if (last_fe !== 1'b1) begin errors++; $display("FAIL frame_err_flag: got %b expected 1", last_fe); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_wait_busy: got %b expected 1", busy); end
    rx = 1'b1;
    wait_clk(32);
    checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL frame_no_repeat: got %0d expected %0d", vcount - v0, 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_parity;
    int v0;
    v0 = vcount_p;
    // 0x07 has three ones: even parity bit should be 1.
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_clk(8);
    checks++; if (vcount_p !== v0 + 1) begin errors++; $display("FAIL par_bad_count: got %0d expected %0d", vcount_p - v0, 1); end
    checks++; if (last_data_p !== 8'h07) begin errors++; $display("FAIL par_bad_data: got %h expected 07", last_data_p); end
    checks++; if (last_pe_p !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b expected 1", last_pe_p); end
    checks++; if (last_fe_p !== 1'b0) begin errors++; $display("FAIL par_bad_frame_err: got %b expected 0", last_fe_p); end
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_clk(8);
    checks++; if (vcount_p !== v0 + 2) begin errors++; $display("FAIL par_good_count: got %0d expected %0d", vcount_p - v0, 2); end
    checks++; if (last_pe_p !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b expected 0", last_pe_p); end
  endtask

  task automatic test_reset_abort;
    int v0;
    v0 = vcount;
    // Start bit, bits 0..3 of 0xFF, then half of bit 4.
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
    wait_clk(16);
    reset = 1'b1;
    wait_clk(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL abort_rx_data: got %h expected 00", rx_data); end
    reset = 1'b0;
    // Remainder of bit 4, bits 5..7 and the stop bit, all high.
    wait_clk(14 + 96 + 32);
    checks++; if (vcount !== v0) begin errors++; $display("FAIL abort_no_valid: got %0d expected 0", vcount - v0); end
    send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
    wait_clk(8);
    checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL abort_next_count: got %0d expected %0d", vcount - v0, 1); end
    checks++; if (last_data !== 8'h12) begin errors++; $display("FAIL abort_next_data: got %h expected 12", last_data); end
  endtask

  initial begin
    rx    = 1'b1;
    rx_p  = 1'b1;
    reset = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_parity();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
